// File: rtl/imem_stim_seq.sv
// Instruction-stimulus sequencer: loadable program store played out over a valid/ready port.
// Build option: define STIM_BUBBLE_EN to inject a NOP bubble after every BUBBLE_GAP program words.
module imem_stim_seq #(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [WIDTH-1:0]      NOP_INSTR  = WIDTH'(32'h00000013),
    parameter int unsigned           BUBBLE_GAP = 4,
    localparam int unsigned          AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      prog_len,
    input  logic             mode_loop,
    input  logic             start,
    input  logic             abort,
    input  logic             instr_ready,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [AW-1:0]    instr_idx,
    output logic             instr_bubble,
    output logic             busy,
    output logic             done,
    output logic [15:0]      wrap_cnt,
    output logic [1:0]       state_dbg
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BUBBLE_GAP < 1) begin : g_bad_param
        $error("imem_stim_seq: DEPTH must be a power of 2 >= 2 and BUBBLE_GAP >= 1");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW:0]        len_q, len_d, eff_len;
    logic               loop_q, loop_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   instr_q, instr_d;
    logic [AW-1:0]      idx_q, idx_d, next_idx;
    logic [15:0]        wrap_q, wrap_d;
    logic               last;
`ifdef STIM_BUBBLE_EN
    logic               bubble_q, bubble_d;
    logic [15:0]        gap_q, gap_d;
`endif

    // Store has no reset so a program survives a harness reset.
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr] <= load_data;
    end

    assign eff_len = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign last    = ({1'b0, idx_q} == len_q - 1'b1);

    // Handshake: a word moves on any edge with instr_valid && instr_ready; while valid is high
    // and ready low the word, index and bubble flag are frozen, and valid only falls after a
    // transfer (or on abort/reset).
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        loop_d   = loop_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        idx_d    = idx_q;
        wrap_d   = wrap_q;
        next_idx = idx_q + 1'b1;
`ifdef STIM_BUBBLE_EN
        bubble_d = bubble_q;
        gap_d    = gap_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort && eff_len != '0) begin
                    state_d = S_RUN;
                    len_d   = eff_len;
                    loop_d  = mode_loop;
                    valid_d = 1'b1;
                    instr_d = mem[0];
                    idx_d   = '0;
                    wrap_d  = '0;
`ifdef STIM_BUBBLE_EN
                    bubble_d = 1'b0;
                    gap_d    = '0;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
`ifdef STIM_BUBBLE_EN
                    bubble_d = 1'b0;
                    gap_d    = '0;
`endif
                end else if (valid_q && instr_ready) begin
`ifdef STIM_BUBBLE_EN
                    if (bubble_q) begin
                        // idx_q already points at the program word the bubble displaced.
                        instr_d  = mem[idx_q];
                        bubble_d = 1'b0;
                    end else
`endif
                    if (last && !loop_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else begin
                        if (last) begin
                            next_idx = '0;
                            if (wrap_q != 16'hFFFF) wrap_d = wrap_q + 16'd1;
                        end
                        idx_d   = next_idx;
                        instr_d = mem[next_idx];
`ifdef STIM_BUBBLE_EN
                        if (gap_q + 16'd1 == 16'(BUBBLE_GAP)) begin
                            instr_d  = NOP_INSTR;
                            bubble_d = 1'b1;
                            gap_d    = '0;
                        end else begin
                            gap_d = gap_q + 16'd1;
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            loop_q  <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            idx_q   <= '0;
            wrap_q  <= '0;
`ifdef STIM_BUBBLE_EN
            bubble_q <= 1'b0;
            gap_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
`ifdef STIM_BUBBLE_EN
            bubble_q <= bubble_d;
            gap_q    <= gap_d;
`endif
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_idx   = idx_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign wrap_cnt    = wrap_q;
    assign state_dbg   = state_q;
`ifdef STIM_BUBBLE_EN
    assign instr_bubble = bubble_q;
`else
    assign instr_bubble = 1'b0;
`endif

endmodule

// File: tb/tb_imem_stim_seq.sv
// Directed self-checking bench for imem_stim_seq (default build, or bubble build with STIM_BUBBLE_EN).
module tb_imem_stim_seq;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic [AW:0]   prog_len;
    logic          mode_loop, start, abort, instr_ready;
    logic          instr_valid, instr_bubble, busy, done;
    logic [W-1:0]  instr;
    logic [AW-1:0] instr_idx;
    logic [15:0]   wrap_cnt;
    logic [1:0]    state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    imem_stim_seq #(.WIDTH(W), .DEPTH(D), .NOP_INSTR(32'h13), .BUBBLE_GAP(2)) dut (
        .clk(clk), .reset_n(reset_n), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .mode_loop(mode_loop), .start(start),
        .abort(abort), .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
        .instr_idx(instr_idx), .instr_bubble(instr_bubble), .busy(busy), .done(done),
        .wrap_cnt(wrap_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW:0] len, input logic lp);
        prog_len = len; mode_loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  instr_valid, 0);
        check({tag, "_instr"},  instr, 32'h13);
        check({tag, "_idx"},    instr_idx, 0);
        check({tag, "_bubble"}, instr_bubble, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_wrap"},   wrap_cnt, 0);
    endtask

    initial begin
        reset_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; mode_loop = 1'b0; start = 1'b0; abort = 1'b0; instr_ready = 1'b1;
        tick(); tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();
        write_word(4'd0, 32'h11);
        write_word(4'd1, 32'h22);
        write_word(4'd2, 32'h33);
        write_word(4'd3, 32'h44);

`ifdef STIM_BUBBLE_EN
        pulse_start(5'd4, 1'b0);
        check("bub_w0", instr, 32'h11);
        check("bub_b0", instr_bubble, 0);
        tick();
        check("bub_w1", instr, 32'h22);
        tick();
        check("bub_w2", instr, 32'h13);
        check("bub_b2", instr_bubble, 1);
        check("bub_v2", instr_valid, 1);
        check("bub_i2", instr_idx, 2);
        tick();
        check("bub_w3", instr, 32'h33);
        check("bub_b3", instr_bubble, 0);
        tick();
        check("bub_w4", instr, 32'h44);
        tick();
        check("bub_done", done, 1);
        check("bub_valid_end", instr_valid, 0);
`else
        // One-shot playback
        pulse_start(5'd4, 1'b0);
        check("os_busy", busy, 1);
        check("os_w0", instr, 32'h11);
        check("os_i0", instr_idx, 0);
        tick(); check("os_w1", instr, 32'h22);
        tick(); check("os_w2", instr, 32'h33);
        tick(); check("os_w3", instr, 32'h44);
        tick();
        check("os_valid_end", instr_valid, 0);
        check("os_nop_end", instr, 32'h13);
        check("os_done", done, 1);
        check("os_busy_end", busy, 0);

        // Looping playback, restarted from DONE
        pulse_start(5'd4, 1'b1);
        check("lp_done_clr", done, 0);
        for (int k = 0; k < 10; k++) begin
            case (k % 4)
                0: exp_q.push_back(32'h11);
                1: exp_q.push_back(32'h22);
                2: exp_q.push_back(32'h33);
                default: exp_q.push_back(32'h44);
            endcase
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("lp_w%0d", k), instr, exp_q.pop_front());
            check($sformatf("lp_busy%0d", k), busy, 1);
            tick();
        end
        check("lp_wrap", wrap_cnt, 2);
        check("lp_next", instr, 32'h33);
        do_abort();
        check("ab_valid", instr_valid, 0);
        check("ab_instr", instr, 32'h13);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);

        // Stall: hold ready low on the second word; a store write must not disturb it
        pulse_start(5'd4, 1'b0);
        tick();
        instr_ready = 1'b0;
        write_word(4'd1, 32'h99);
        check("st_w0", instr, 32'h22);
        check("st_i0", instr_idx, 1);
        for (int k = 1; k < 3; k++) begin
            tick();
            check($sformatf("st_w%0d", k), instr, 32'h22);
            check($sformatf("st_i%0d", k), instr_idx, 1);
            check($sformatf("st_v%0d", k), instr_valid, 1);
        end
        instr_ready = 1'b1;
        tick(); check("st_after", instr, 32'h33);
        tick(); check("st_after2", instr, 32'h44);
        tick(); check("st_done", done, 1);
        write_word(4'd1, 32'h22);

        // Write on the same edge that fetches index 2
        pulse_start(5'd4, 1'b1);
        tick();
        check("rw_pre", instr_idx, 1);
        load_we = 1'b1; load_addr = 4'd2; load_data = 32'hAA;
        tick();
        load_we = 1'b0;
        check("rw_old", instr, 32'h33);
        tick(); check("rw_w3", instr, 32'h44);
        tick(); check("rw_w0", instr, 32'h11);
        tick(); check("rw_w1", instr, 32'h22);
        tick(); check("rw_new", instr, 32'hAA);
        check("rw_wrap", wrap_cnt, 1);

        // Asynchronous reset mid-run
        tick();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("areset");
        reset_n = 1'b1;
        tick();
        pulse_start(5'd4, 1'b0);
        check("ar_w0", instr, 32'h11);
        tick(); check("ar_w1", instr, 32'h22);
        tick(); check("ar_keep", instr, 32'hAA);
        do_abort();
        write_word(4'd2, 32'h33);

        // Boundaries: zero length, start+abort, single-entry loop, start while running
        pulse_start(5'd0, 1'b0);
        check("len0_busy", busy, 0);
        check("len0_valid", instr_valid, 0);
        abort = 1'b1;
        pulse_start(5'd4, 1'b0);
        abort = 1'b0;
        check("sa_busy", busy, 0);
        pulse_start(5'd1, 1'b1);
        check("l1_w0", instr, 32'h11);
        check("l1_wrap0", wrap_cnt, 0);
        tick(); check("l1_wrap1", wrap_cnt, 1);
        check("l1_w1", instr, 32'h11);
        tick(); check("l1_wrap2", wrap_cnt, 2);
        pulse_start(5'd4, 1'b0);
        check("rs_idx", instr_idx, 0);
        check("rs_wrap", wrap_cnt, 3);
        check("rs_busy", busy, 1);
        do_abort();

        // Length larger than depth clamps to DEPTH: entry 15 wraps to 0
        write_word(4'd15, 32'hFF);
        pulse_start(5'd20, 1'b1);
        for (int k = 0; k < 15; k++) tick();
        check("cl_w15", instr, 32'hFF);
        check("cl_i15", instr_idx, 15);
        tick();
        check("cl_wrapw", instr, 32'h11);
        check("cl_wrap", wrap_cnt, 1);
        do_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
